// File: rtl/ldm_stm_seq.sv
// LDM/STM/PUSH/POP sequencer: walks a 15-bit register list and moves one register per accepted bus beat.
// Loads use register-file write port 1. The base-register writeback uses write port 2 in FIN.
module ldm_stm_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        LOAD,
    input  logic        DESCEND,
    input  logic        WBACK,
    input  logic [3:0]  BASE_RN,
    input  logic [31:0] BASE_ADDR,
    input  logic [14:0] RLIST,
    output logic        BUSY,
    output logic        DONE,
    output logic        MREQ,
    output logic        MWRITE,
    output logic [31:0] MADDR,
    output logic [31:0] MWDATA,
    input  logic        MREADY,
    input  logic [31:0] MRDATA,
    output logic [3:0]  RA,
    input  logic [31:0] RDATA,
    output logic        WEN1,
    output logic [3:0]  WA1,
    output logic [31:0] DI1,
    output logic        WEN2,
    output logic [3:0]  WA2,
    output logic [31:0] DI2
);

    typedef enum logic [1:0] {IDLE, CALC, XFER, FIN} state_t;

    state_t      state_q, state_d;
    logic        load_q, load_d, desc_q, desc_d, wback_q, wback_d;
    logic [3:0]  rn_q, rn_d;
    logic [31:0] base_q, base_d, final_q, final_d;
    logic [14:0] rlist_q, rlist_d, rem_q, rem_d;
    logic        busy_q, busy_d, done_q, done_d, mreq_q, mreq_d, mwrite_q, mwrite_d;
    logic [31:0] maddr_q, maddr_d, di2_q, di2_d;
    logic [3:0]  ra_q, ra_d, wa2_q, wa2_d;
    logic        wen2_q, wen2_d;

    logic [15:0] rl16;
    logic        wb_ok;
    logic [4:0]  n_cnt;
    logic [31:0] four_n, start_addr, fin_addr;
    logic [14:0] rem_nx;

    function automatic logic [3:0] lowest(input logic [14:0] v);
        lowest = 4'd0;
        for (int i = 14; i >= 0; i--)
            if (v[i]) lowest = 4'(i);
    endfunction

    function automatic logic [4:0] popcnt(input logic [14:0] v);
        popcnt = 5'd0;
        for (int i = 0; i < 15; i++)
            popcnt = popcnt + {4'd0, v[i]};
    endfunction

    // A base register that is also loaded keeps the loaded value; r15 is not in the file.
    assign rl16  = {1'b0, rlist_q};
    assign wb_ok = wback_q && (rn_q != 4'd15) && !(load_q && rl16[rn_q]);

    assign n_cnt      = popcnt(rlist_q);
    assign four_n     = {25'd0, n_cnt, 2'b00};
    assign start_addr = desc_q ? base_q - four_n : base_q;
    assign fin_addr   = desc_q ? base_q - four_n : base_q + four_n;
    assign rem_nx     = rem_q & (rem_q - 15'd1);

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        desc_d   = desc_q;
        wback_d  = wback_q;
        rn_d     = rn_q;
        base_d   = base_q;
        rlist_d  = rlist_q;
        final_d  = final_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mreq_d   = mreq_q;
        mwrite_d = mwrite_q;
        maddr_d  = maddr_q;
        ra_d     = ra_q;
        wen2_d   = 1'b0;
        wa2_d    = 4'd0;
        di2_d    = 32'd0;
        case (state_q)
            IDLE: if (START) begin
                state_d = CALC;
                load_d  = LOAD;
                desc_d  = DESCEND;
                wback_d = WBACK;
                rn_d    = BASE_RN;
                base_d  = BASE_ADDR;
                rlist_d = RLIST;
                busy_d  = 1'b1;
            end
            CALC: begin
                final_d = fin_addr;
                if (n_cnt == 5'd0) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    if (wb_ok) begin
                        wen2_d = 1'b1;
                        wa2_d  = rn_q;
                        di2_d  = fin_addr;
                    end
                end else begin
                    state_d  = XFER;
                    rem_d    = rlist_q;
                    mreq_d   = 1'b1;
                    mwrite_d = !load_q;
                    maddr_d  = {start_addr[31:2], 2'b00};
                    ra_d     = lowest(rlist_q);
                end
            end
            XFER: if (MREADY) begin
                rem_d = rem_nx;
                if (rem_nx == 15'd0) begin
                    state_d  = FIN;
                    mreq_d   = 1'b0;
                    mwrite_d = 1'b0;
                    maddr_d  = 32'd0;
                    ra_d     = 4'd0;
                    done_d   = 1'b1;
                    if (wb_ok) begin
                        wen2_d = 1'b1;
                        wa2_d  = rn_q;
                        di2_d  = final_q;
                    end
                end else begin
                    maddr_d = maddr_q + 32'd4;
                    ra_d    = lowest(rem_nx);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            desc_q   <= 1'b0;
            wback_q  <= 1'b0;
            rn_q     <= 4'd0;
            base_q   <= 32'd0;
            rlist_q  <= 15'd0;
            final_q  <= 32'd0;
            rem_q    <= 15'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwrite_q <= 1'b0;
            maddr_q  <= 32'd0;
            ra_q     <= 4'd0;
            wen2_q   <= 1'b0;
            wa2_q    <= 4'd0;
            di2_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            desc_q   <= desc_d;
            wback_q  <= wback_d;
            rn_q     <= rn_d;
            base_q   <= base_d;
            rlist_q  <= rlist_d;
            final_q  <= final_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mreq_q   <= mreq_d;
            mwrite_q <= mwrite_d;
            maddr_q  <= maddr_d;
            ra_q     <= ra_d;
            wen2_q   <= wen2_d;
            wa2_q    <= wa2_d;
            di2_q    <= di2_d;
        end
    end

    // Data paths follow the live bus/register-file handshake within the beat.
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign MREQ   = mreq_q;
    assign MWRITE = mwrite_q;
    assign MADDR  = maddr_q;
    assign RA     = ra_q;
    assign MWDATA = (mreq_q && mwrite_q) ? RDATA : 32'd0;
    assign WEN1   = mreq_q && !mwrite_q && MREADY;
    assign WA1    = WEN1 ? ra_q : 4'd0;
    assign DI1    = WEN1 ? MRDATA : 32'd0;
    assign WEN2   = wen2_q;
    assign WA2    = wa2_q;
    assign DI2    = di2_q;

endmodule
